multi_ch_pulse_sequencer: RTL and testbench

- Parametrised successor to the single-channel reset/downtime/start sequencer.
- Drives per-channel reset and start strobes for up to N_CH measurement channels. Each enabled channel gets one reset → downtime → active sequence, in ascending index order, repeated for a programmable number of runs.
- Phase lengths are run-time inputs latched at launch. The block adds a go/busy/done handshake, abort, and error reporting.
- Sits between the host control registers and the per-channel front-end blocks.

---
 rtl/multi_ch_seq_pkg.sv | 43 ++++
 rtl/seq_phase_timer.sv | 27 ++
 rtl/multi_ch_pulse_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multi_ch_pulse_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_ch_seq_pkg.sv
// rtl/multi_ch_seq_pkg.sv - shared types and channel-select helpers for the multi-channel pulse sequencer
package multi_ch_seq_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RESET  = 2'b01,
        ACTIVE = 2'b10,
        DOWN   = 2'b11
    } seq_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } ch_sel_t;

    // Descending scan so the last hit is the lowest qualifying bit.
    function automatic ch_sel_t next_enabled(input logic [MAX_CH-1:0] mask, input logic [3:0] cur);
        ch_sel_t sel;
        sel = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                sel.found = 1'b1;
                sel.idx   = 4'(i);
            end
        end
        return sel;
    endfunction

    function automatic ch_sel_t first_enabled(input logic [MAX_CH-1:0] mask);
        ch_sel_t sel;
        sel = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel.found = 1'b1;
                sel.idx   = 4'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// rtl/seq_phase_timer.sv - down-counting phase timer, expire flags the last cycle of a phase
module seq_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;

    // A zero length still yields a one-cycle phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (len == '0) ? '0 : len - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/multi_ch_pulse_sequencer.sv
// rtl/multi_ch_pulse_sequencer.sv - per-channel reset/downtime/active strobe sequencer with run count and abort
module multi_ch_pulse_sequencer
    import multi_ch_seq_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int RUN_W = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [CNT_W-1:0] reset_len,
    input  logic [CNT_W-1:0] down_len,
    input  logic [CNT_W-1:0] duration,
    input  logic [RUN_W-1:0] n_runs,
    output logic [N_CH-1:0]  ch_reset,
    output logic [N_CH-1:0]  ch_start,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [CH_W-1:0]  cur_ch,
    output logic [RUN_W-1:0] cur_run
);

    localparam logic [N_CH-1:0] ONE = N_CH'(1);

    seq_state_t       state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d, first_ch_q;
    logic [RUN_W-1:0] run_q, run_d, runs_q;
    logic [N_CH-1:0]  mask_q;
    logic [CNT_W-1:0] reset_len_q, down_len_q, duration_q;
    logic             latch, tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_len;
    logic             done_d, aborted_d, err_d;
    ch_sel_t          launch_sel, nxt_sel;

    seq_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            run_q   <= run_d;
        end
    end

    // The launch cycle feeds the raw reset_len to the timer since the latched copy is not yet valid.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        run_d      = run_q;
        latch      = 1'b0;
        tmr_load   = 1'b0;
        tmr_len    = reset_len_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        err_d      = 1'b0;
        launch_sel = first_enabled(MAX_CH'(ch_en));
        nxt_sel    = next_enabled(MAX_CH'(mask_q), 4'(ch_q));
        case (state_q)
            IDLE: begin
                if (go && !abort) begin
                    if (launch_sel.found) begin
                        latch    = 1'b1;
                        state_d  = RESET;
                        ch_d     = CH_W'(launch_sel.idx);
                        run_d    = '0;
                        tmr_load = 1'b1;
                        tmr_len  = reset_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RESET: begin
                if (tmr_expire) begin
                    state_d  = DOWN;
                    tmr_load = 1'b1;
                    tmr_len  = down_len_q;
                end
            end
            DOWN: begin
                if (tmr_expire) begin
                    state_d  = ACTIVE;
                    tmr_load = 1'b1;
                    tmr_len  = duration_q;
                end
            end
            ACTIVE: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    state_d  = RESET;
                    if (nxt_sel.found) begin
                        ch_d = CH_W'(nxt_sel.idx);
                    end else if (run_q != runs_q - RUN_W'(1)) begin
                        run_d = run_q + RUN_W'(1);
                        ch_d  = first_ch_q;
                    end else begin
                        state_d  = IDLE;
                        tmr_load = 1'b0;
                        done_d   = 1'b1;
                        ch_d     = '0;
                        run_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            ch_d      = '0;
            run_d     = '0;
            tmr_load  = 1'b0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            first_ch_q  <= '0;
            reset_len_q <= '0;
            down_len_q  <= '0;
            duration_q  <= '0;
            runs_q      <= '0;
        end else if (latch) begin
            mask_q      <= ch_en;
            first_ch_q  <= CH_W'(launch_sel.idx);
            reset_len_q <= reset_len;
            down_len_q  <= down_len;
            duration_q  <= duration;
            runs_q      <= (n_runs == '0) ? RUN_W'(1) : n_runs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_reset <= '0;
            ch_start <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            err      <= 1'b0;
        end else begin
            ch_reset <= (state_d == RESET)  ? (ONE << ch_d) : '0;
            ch_start <= (state_d == ACTIVE) ? (ONE << ch_d) : '0;
            busy     <= (state_d != IDLE);
            done     <= done_d;
            aborted  <= aborted_d;
            err      <= err_d;
        end
    end

    assign cur_ch  = ch_q;
    assign cur_run = run_q;

endmodule

// File: tb/tb_multi_ch_pulse_sequencer.sv
// tb/tb_multi_ch_pulse_sequencer.sv - scoreboard bench for multi_ch_pulse_sequencer
module tb_multi_ch_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  ch_en = '0;
    logic [15:0] reset_len = '0, down_len = '0, duration = '0;
    logic [7:0]  n_runs = '0;
    logic [3:0]  ch_reset, ch_start;
    logic        busy, done, aborted, err;
    logic [1:0]  cur_ch;
    logic [7:0]  cur_run;

    multi_ch_pulse_sequencer #(.N_CH(4), .CNT_W(16), .RUN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .ch_en(ch_en),
        .reset_len(reset_len), .down_len(down_len), .duration(duration), .n_runs(n_runs),
        .ch_reset(ch_reset), .ch_start(ch_start), .busy(busy), .done(done),
        .aborted(aborted), .err(err), .cur_ch(cur_ch), .cur_run(cur_run)
    );

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] st;
        logic       bsy;
        logic       dn;
        logic       ab;
        logic       er;
        logic [1:0] ch;
        logic [7:0] run;
    } obs_t;

    obs_t exp_q[$];
    int   cyc_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    obs_t got, e_o;
    int   e_c;
    int   t0;

    assign got = {ch_reset, ch_start, busy, done, aborted, err, cur_ch, cur_run};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic [3:0] rs, input logic [3:0] st, input logic b,
                                input logic d, input logic a, input logic e,
                                input logic [1:0] ch, input logic [7:0] run);
        return {rs, st, b, d, a, e, ch, run};
    endfunction

    task automatic push(input int c, input obs_t o);
        exp_q.push_back(o);
        cyc_q.push_back(c);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // term: 0 = done pulse, 1 = aborted pulse after offset cut, 2 = nothing (reset cut)
    task automatic expect_seq(input int ts, input logic [3:0] m, input int r, input int d,
                              input int a, input int nr, input int cut, input int term);
        int off;
        logic [3:0] oh;
        if (r == 0) r = 1;
        if (d == 0) d = 1;
        if (a == 0) a = 1;
        if (nr == 0) nr = 1;
        off = 1;
        for (int run = 0; run < nr; run++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (m[ch]) begin
                    oh = 4'(1 << ch);
                    for (int i = 0; i < r; i++) begin
                        if (off <= cut) push(ts + off, mk(oh, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(ch), 8'(run)));
                        off++;
                    end
                    for (int i = 0; i < d; i++) begin
                        if (off <= cut) push(ts + off, mk(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(ch), 8'(run)));
                        off++;
                    end
                    for (int i = 0; i < a; i++) begin
                        if (off <= cut) push(ts + off, mk(4'h0, oh, 1'b1, 1'b0, 1'b0, 1'b0, 2'(ch), 8'(run)));
                        off++;
                    end
                end
            end
        end
        if (term == 0) push(ts + off, mk(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
        else if (term == 1) push(ts + cut + 1, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0));
    endtask

    // Inputs are scrambled after go so any use of unlatched config shows up.
    task automatic launch(input logic [3:0] m, input int r, input int d, input int a,
                          input int nr, input int cut, input int term, output int ts);
        @(posedge clk); #1;
        ch_en = m; reset_len = 16'(r); down_len = 16'(d); duration = 16'(a); n_runs = 8'(nr);
        go = 1'b1;
        ts = cyc;
        expect_seq(ts, m, r, d, a, nr, cut, term);
        @(posedge clk); #1;
        go = 1'b0;
        ch_en = ~m; reset_len = 16'd7; down_len = 16'd9; duration = 16'd3; n_runs = 8'd5;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_idle_busy"}, int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (busy || done || aborted || err)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cycle %0d: got %h expected none", cyc, got);
            end else begin
                e_o = exp_q.pop_front();
                e_c = cyc_q.pop_front();
                if (got !== e_o || e_c != cyc) begin
                    n_fail++;
                    $display("FAIL scoreboard: got %h at cycle %0d, expected %h at cycle %0d",
                             got, cyc, e_o, e_c);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(got), 0);
        rst_n = 1'b1;

        launch(4'b0001, 3, 2, 5, 1, 1000, 0, t0);
        drain("single_ch");

        launch(4'b1010, 1, 1, 1, 2, 1000, 0, t0);
        drain("two_ch_two_runs");

        launch(4'b0100, 0, 0, 0, 0, 1000, 0, t0);
        drain("zero_lengths");

        @(posedge clk); #1;
        ch_en = 4'b0000; go = 1'b1;
        push(cyc + 1, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0));
        @(posedge clk); #1;
        go = 1'b0;
        drain("empty_mask_err");

        launch(4'b0001, 3, 2, 100, 1, 20, 1, t0);
        wait_until(t0 + 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        drain("abort_active");

        launch(4'b0110, 2, 1, 3, 3, 1000, 0, t0);
        drain("relaunch_after_abort");

        @(posedge clk); #1;
        ch_en = 4'b0011; go = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_go_idle_busy", int'(busy), 0);

        launch(4'b1000, 65535, 1, 1, 1, 10, 1, t0);
        wait_until(t0 + 10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        drain("max_len_abort");

        launch(4'b0001, 10, 1, 1, 1, 4, 2, t0);
        wait_until(t0 + 5);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(got), 0);
        chk("async_reset_pending", exp_q.size(), 0);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_busy", int'(busy), 0);

        launch(4'b1111, 1, 1, 1, 1, 1000, 0, t0);
        drain("relaunch_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
